// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-unit bundle: pipeline register tags and memory handshake in, operand selects
// and stage stall/flush enables out. WIDTH and CNT_W must match the unit's parameters.
interface hazard_ctrl_unit_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] RegS1D;
    logic [WIDTH-1:0] RegS2D;
    logic [WIDTH-1:0] RegS1E;
    logic [WIDTH-1:0] RegS2E;
    logic [WIDTH-1:0] WriteRegE;
    logic             MemReadE;
    logic [WIDTH-1:0] WriteRegM;
    logic             RegWM;
    logic             MemAccM;
    logic             mem_ready;
    logic [WIDTH-1:0] WriteRegWB;
    logic             RegWWB;
    logic             BranchE;
    logic [1:0]       src1;
    logic [1:0]       src2;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output RegS1D, RegS2D, RegS1E, RegS2E, WriteRegE, MemReadE,
               WriteRegM, RegWM, MemAccM, mem_ready, WriteRegWB, RegWWB, BranchE,
        input  src1, src2, stallF, stallD, stallE, stallM, flushD, flushE,
               mem_timeout, stall_cnt
    );

    modport slave (
        input  RegS1D, RegS2D, RegS1E, RegS2E, WriteRegE, MemReadE,
               WriteRegM, RegWM, MemAccM, mem_ready, WriteRegWB, RegWWB, BranchE,
        output src1, src2, stallF, stallD, stallE, stallM, flushD, flushE,
               mem_timeout, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline hazard controller: MEM/WB forwarding, load-use stall, data-memory
// wait FSM with sticky timeout, branch flush arbitration and a saturating stall counter.
module hazard_ctrl_unit #(
    parameter int WIDTH    = 5,
    parameter int ZERO_REG = 1,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_ctrl_unit_if.slave hz
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    logic [1:0]       stateReg;
    logic [1:0]       stateNext;
    logic [7:0]       waitCntReg;
    logic [7:0]       waitCntNext;
    logic [CNT_W-1:0] stallCntReg;

    logic [WIDTH-1:0] srcE [2];
    logic [1:0]       fwdSel [2];
    logic             luHaz;
    logic             memWait;
    logic             inError;
    logic             stallFInt;
    logic             stallDInt;
    logic             stallEInt;
    logic             stallMInt;
    logic             flushDInt;
    logic             flushEInt;

    assign srcE[0] = hz.RegS1E;
    assign srcE[1] = hz.RegS2E;

    // MEM result is younger than WB, so it wins when both match.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic zeroHit;
        assign zeroHit    = (ZERO_REG != 0) && (srcE[gi] == '0);
        assign fwdSel[gi] = rst ? 2'b00 :
                            (hz.RegWM  && (hz.WriteRegM  == srcE[gi]) && !zeroHit) ? 2'b01 :
                            (hz.RegWWB && (hz.WriteRegWB == srcE[gi]) && !zeroHit) ? 2'b10 :
                            2'b00;
    end

    assign hz.src1 = fwdSel[0];
    assign hz.src2 = fwdSel[1];

    assign luHaz = hz.MemReadE
                && !((ZERO_REG != 0) && (hz.WriteRegE == '0))
                && ((hz.WriteRegE == hz.RegS1D) || (hz.WriteRegE == hz.RegS2D));

    // Stall from the very first cycle an unready access shows up, before the FSM moves.
    assign memWait = !hz.mem_ready
                  && ((stateReg == MEM_WAIT) || ((stateReg == IDLE) && hz.MemAccM));
    assign inError = (stateReg == ERROR);

    always_comb begin
        stallFInt = 1'b0;
        stallDInt = 1'b0;
        stallEInt = 1'b0;
        stallMInt = 1'b0;
        flushDInt = 1'b0;
        flushEInt = 1'b0;
        if (rst) begin
            stallFInt = 1'b0;
        end else if (inError || memWait) begin
            stallFInt = 1'b1;
            stallDInt = 1'b1;
            stallEInt = 1'b1;
            stallMInt = 1'b1;
        end else if (hz.BranchE) begin
            // The load consumer is on the wrong path, so the flush overrides its stall.
            flushDInt = 1'b1;
            flushEInt = 1'b1;
        end else if (luHaz) begin
            stallFInt = 1'b1;
            stallDInt = 1'b1;
            flushEInt = 1'b1;
        end
    end

    assign hz.stallF      = stallFInt;
    assign hz.stallD      = stallDInt;
    assign hz.stallE      = stallEInt;
    assign hz.stallM      = stallMInt;
    assign hz.flushD      = flushDInt;
    assign hz.flushE      = flushEInt;
    assign hz.mem_timeout = inError;
    assign hz.stall_cnt   = stallCntReg;

    // waitCnt counts stalled wait cycles including the IDLE cycle that saw the access.
    always_comb begin
        stateNext   = stateReg;
        waitCntNext = waitCntReg;
        case (stateReg)
            IDLE: begin
                if (hz.MemAccM && !hz.mem_ready) begin
                    if (WAIT_LIM <= 8'd1) begin
                        stateNext = ERROR;
                    end else begin
                        stateNext   = MEM_WAIT;
                        waitCntNext = 8'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    stateNext   = IDLE;
                    waitCntNext = 8'd0;
                end else if ((waitCntReg + 8'd1) >= WAIT_LIM) begin
                    stateNext = ERROR;
                end else begin
                    waitCntNext = waitCntReg + 8'd1;
                end
            end
            ERROR:   stateNext = ERROR;
            default: begin
                stateNext   = IDLE;
                waitCntNext = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg    <= IDLE;
            waitCntReg  <= 8'd0;
            stallCntReg <= '0;
        end else begin
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
            if (stallFInt && (stallCntReg != {CNT_W{1'b1}})) begin
                stallCntReg <= stallCntReg + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboarded bench: two hazard units (different ZERO_REG/WAIT_MAX/CNT_W) share one
// stimulus stream; a rule-level model predicts each cycle, a monitor compares.
module tb_hazard_ctrl_unit;
    typedef struct packed {
        logic       rst;
        logic [4:0] s1d, s2d, s1e, s2e, wre, wrm, wrwb;
        logic       memReadE, regWM, memAccM, memReady, regWWB, branchE;
    } stim_t;

    typedef struct {
        int          dut;
        int          txn;
        logic [10:0] ctrl;
        int          cnt;
    } exp_t;

    logic  clk;
    logic  rst;
    stim_t cur;
    exp_t  q[$];
    int    nTests = 0;
    int    nFail  = 0;
    int    txnNo  = 0;

    // Model parameters and state per unit.
    int zrP[2]   = '{1, 0};
    int wmaxP[2] = '{4, 6};
    int cmaxP[2] = '{65535, 3};
    int waitRun[2];
    bit dead[2];
    int cnt[2];

    hazard_ctrl_unit_if #(.WIDTH(5), .CNT_W(16)) ifA ();
    hazard_ctrl_unit_if #(.WIDTH(5), .CNT_W(2))  ifB ();

    hazard_ctrl_unit #(.WIDTH(5), .ZERO_REG(1), .WAIT_MAX(4), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .hz(ifA.slave));
    hazard_ctrl_unit #(.WIDTH(5), .ZERO_REG(0), .WAIT_MAX(6), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst), .hz(ifB.slave));

    assign rst = cur.rst;
    assign ifA.RegS1D = cur.s1d;       assign ifB.RegS1D = cur.s1d;
    assign ifA.RegS2D = cur.s2d;       assign ifB.RegS2D = cur.s2d;
    assign ifA.RegS1E = cur.s1e;       assign ifB.RegS1E = cur.s1e;
    assign ifA.RegS2E = cur.s2e;       assign ifB.RegS2E = cur.s2e;
    assign ifA.WriteRegE = cur.wre;    assign ifB.WriteRegE = cur.wre;
    assign ifA.MemReadE = cur.memReadE; assign ifB.MemReadE = cur.memReadE;
    assign ifA.WriteRegM = cur.wrm;    assign ifB.WriteRegM = cur.wrm;
    assign ifA.RegWM = cur.regWM;      assign ifB.RegWM = cur.regWM;
    assign ifA.MemAccM = cur.memAccM;  assign ifB.MemAccM = cur.memAccM;
    assign ifA.mem_ready = cur.memReady; assign ifB.mem_ready = cur.memReady;
    assign ifA.WriteRegWB = cur.wrwb;  assign ifB.WriteRegWB = cur.wrwb;
    assign ifA.RegWWB = cur.regWWB;    assign ifB.RegWWB = cur.regWWB;
    assign ifA.BranchE = cur.branchE;  assign ifB.BranchE = cur.branchE;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] fwdModel(input logic [4:0] src, input stim_t s, input int zr);
        if (zr != 0 && src == 0) return 2'b00;
        if (s.regWM && s.wrm == src) return 2'b01;
        if (s.regWWB && s.wrwb == src) return 2'b10;
        return 2'b00;
    endfunction

    // Predict this cycle's outputs from current inputs, then advance to the next edge.
    function automatic void modelStep(input int d, input stim_t s);
        exp_t e;
        bit lu, mw, sF, sD, sE, sM, fD, fE;
        e.dut = d;
        e.txn = txnNo;
        if (s.rst) begin
            waitRun[d] = 0;
            dead[d]    = 0;
            cnt[d]     = 0;
            e.ctrl     = '0;
            e.cnt      = 0;
            q.push_back(e);
            return;
        end
        lu = s.memReadE && !(zrP[d] != 0 && s.wre == 0) && (s.wre == s.s1d || s.wre == s.s2d);
        mw = !dead[d] && !s.memReady && (waitRun[d] > 0 || s.memAccM);
        {sF, sD, sE, sM, fD, fE} = '0;
        if (dead[d] || mw)   {sF, sD, sE, sM} = 4'b1111;
        else if (s.branchE)  {fD, fE} = 2'b11;
        else if (lu)         {sF, sD, fE} = 3'b111;
        e.ctrl = {fwdModel(s.s1e, s, zrP[d]), fwdModel(s.s2e, s, zrP[d]),
                  sF, sD, sE, sM, fD, fE, dead[d]};
        e.cnt  = cnt[d];
        q.push_back(e);
        if (sF && cnt[d] < cmaxP[d]) cnt[d]++;
        if (!dead[d]) begin
            if (mw) begin
                waitRun[d]++;
                if (waitRun[d] >= wmaxP[d]) dead[d] = 1;
            end else begin
                waitRun[d] = 0;
            end
        end
    endfunction

    task automatic step(input stim_t s);
        @(negedge clk);
        cur = s;
        modelStep(0, s);
        modelStep(1, s);
        txnNo++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.memReady = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input int txn, input int d,
                         input int act, input int req);
        nTests++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s txn=%0d dut%0d actual=%0h required=%0h", name, txn, d, act, req);
        end
    endtask

    // Monitor: every cycle the outputs are settled well before the next rising edge.
    initial begin
        exp_t e;
        logic [10:0] actCtrl;
        int actCnt;
        forever begin
            @(negedge clk);
            #3;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    actCtrl = {ifA.src1, ifA.src2, ifA.stallF, ifA.stallD, ifA.stallE,
                               ifA.stallM, ifA.flushD, ifA.flushE, ifA.mem_timeout};
                    actCnt  = int'(ifA.stall_cnt);
                end else begin
                    actCtrl = {ifB.src1, ifB.src2, ifB.stallF, ifB.stallD, ifB.stallE,
                               ifB.stallM, ifB.flushD, ifB.flushE, ifB.mem_timeout};
                    actCnt  = int'(ifB.stall_cnt);
                end
                check("ctrl", e.txn, e.dut, int'(actCtrl), int'(e.ctrl));
                check("stall_cnt", e.txn, e.dut, actCnt, e.cnt);
                $display("[TB] txn %0d dut%0d ctrl=%b cnt=%0d", e.txn, e.dut, actCtrl, actCnt);
            end
        end
    end

    initial begin
        stim_t s;
        int budget;
        cur = idle();
        cur.rst = 1'b1;
        s = idle(); s.rst = 1'b1;
        step(s); step(s);

        // Forwarding priority MEM > WB > none.
        s = idle(); s.s1e = 1; s.wrm = 1; s.regWM = 1; s.wrwb = 1; s.regWWB = 1;
        step(s);
        s.regWM = 0;  step(s);
        s.regWWB = 0; step(s);

        // Register zero: blocked on unit A, forwarded on unit B.
        s = idle(); s.regWM = 1;
        step(s);

        // Load-use for one cycle, then clear.
        s = idle(); s.memReadE = 1; s.wre = 9; s.s2d = 9; s.s1d = 3;
        step(s);
        s.memReadE = 0; step(s);

        // Memory wait: three unready cycles then ready.
        s = idle(); s.memAccM = 1; s.memReady = 0;
        repeat (3) step(s);
        s.memReady = 1; step(s);
        step(idle());

        // Branch together with load-use: branch wins.
        s = idle(); s.memReadE = 1; s.wre = 7; s.s1d = 7; s.branchE = 1;
        step(s);
        s.branchE = 0; step(s);
        step(idle());

        // Timeout: A trips after 4 waits, B after 6; then asynchronous reset mid-cycle.
        s = idle(); s.memAccM = 1; s.memReady = 0;
        repeat (9) step(s);
        step(idle());
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());

        // Saturation of the 2-bit counter after five stall cycles.
        s = idle(); s.memReadE = 1; s.wre = 5; s.s1d = 5;
        repeat (5) step(s);
        step(idle());

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            s = idle();
            s.rst      = ($urandom_range(0, 49) == 0);
            s.s1d      = 5'($urandom_range(0, 3));
            s.s2d      = 5'($urandom_range(0, 3));
            s.s1e      = 5'($urandom_range(0, 3));
            s.s2e      = 5'($urandom_range(0, 3));
            s.wre      = 5'($urandom_range(0, 3));
            s.wrm      = 5'($urandom_range(0, 3));
            s.wrwb     = 5'($urandom_range(0, 3));
            s.memReadE = 1'($urandom_range(0, 1));
            s.regWM    = 1'($urandom_range(0, 1));
            s.regWWB   = 1'($urandom_range(0, 1));
            s.memAccM  = ($urandom_range(0, 3) == 0);
            s.memReady = ($urandom_range(0, 2) != 0);
            s.branchE  = ($urandom_range(0, 4) == 0);
            step(s);
        end
        step(idle());

        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        if (q.size() > 0) begin
            nTests++;
            nFail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
